// File: rtl/tdm_demux_1_4_if.sv
// rtl/tdm_demux_1_4_if.sv - serial TDM sample stream bundle feeding the 1:4 demultiplexer
//
// Purpose: carries one TDM sample per cycle from the link front end into tdm_demux_1_4.
// Signals:
//   din         W-bit incoming sample
//   din_valid   din carries a sample this cycle (no backpressure)
//   frame_sync  qualified by din_valid; marks the channel-0 sample of a frame
// Modports:
//   master  sample source (drives all signals)
//   slave   demultiplexer (samples all signals)

interface tdm_demux_1_4_if #(
  parameter int W = 8
);

  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;

  modport master (
    output din,
    output din_valid,
    output frame_sync
  );

  modport slave (
    input din,
    input din_valid,
    input frame_sync
  );

endinterface

// File: rtl/tdm_demux_1_4.sv
// rtl/tdm_demux_1_4.sv - 1-to-4 time-division demultiplexer with frame alignment tracking
//
// Purpose: receive end of a 4-channel TDM link. Each accepted sample is steered
// to its own registered lane; frame alignment is tracked from the channel-0
// frame_sync marker, alignment faults raise a sticky flag, and a strobe pulses
// when a clean 0..3 frame has landed.
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   rx           slave side of tdm_demux_1_4_if (din, din_valid, frame_sync)
//   err_clr      clears sticky sync_err (a same-cycle fault takes priority)
//   dout         lane registers, lane k at [k*W +: W]
//   ch_strobe    one-hot, 1-cycle pulse: lane k updated this cycle
//   frame_valid  1-cycle pulse with ch_strobe[3] when a clean frame completes
//   ch_idx       next expected channel (0 while hunting)
//   locked       1 while frame alignment is held
//   sync_err     sticky alignment-fault flag

module tdm_demux_1_4 #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tdm_demux_1_4_if.slave        rx,
  input  logic                  err_clr,
  output logic [4*W-1:0]        dout,
  output logic [3:0]            ch_strobe,
  output logic                  frame_valid,
  output logic [1:0]            ch_idx,
  output logic                  locked,
  output logic                  sync_err
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t       state;
  logic [W-1:0] lane [4];
  // Set when the current frame began with a proper channel-0 sync; gates
  // frame_valid so a frame entered part-way never reports as complete.
  logic         frame_clean;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_lane_out
      assign dout[g*W +: W] = lane[g];
    end
  endgenerate

  assign locked = (state == LOCK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= HUNT;
      ch_idx      <= 2'd0;
      ch_strobe   <= 4'b0000;
      frame_valid <= 1'b0;
      frame_clean <= 1'b0;
      sync_err    <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        lane[k] <= '0;
      end
    end else begin
      // Pulses default low; they are only raised on an accepted sample.
      ch_strobe   <= 4'b0000;
      frame_valid <= 1'b0;

      // Clear first so any fault raised below in the same cycle wins.
      if (err_clr) begin
        sync_err <= 1'b0;
      end

      if (rx.din_valid) begin
        case (state)
          HUNT: begin
            // Everything before the first sync marker is discarded.
            if (rx.frame_sync) begin
              lane[0]     <= rx.din;
              ch_strobe   <= 4'b0001;
              ch_idx      <= 2'd1;
              frame_clean <= 1'b1;
              state       <= LOCK;
            end
          end

          LOCK: begin
            if (ch_idx == 2'd0) begin
              if (rx.frame_sync) begin
                // Expected start of the next frame.
                lane[0]     <= rx.din;
                ch_strobe   <= 4'b0001;
                ch_idx      <= 2'd1;
                frame_clean <= 1'b1;
              end else begin
                // Sync missing where channel 0 should be: alignment lost.
                sync_err    <= 1'b1;
                ch_idx      <= 2'd0;
                frame_clean <= 1'b0;
                state       <= HUNT;
              end
            end else begin
              if (rx.frame_sync) begin
                // Early sync: abandon the partial frame and realign on this
                // sample as channel 0 without dropping lock.
                sync_err    <= 1'b1;
                lane[0]     <= rx.din;
                ch_strobe   <= 4'b0001;
                ch_idx      <= 2'd1;
                frame_clean <= 1'b1;
              end else begin
                lane[ch_idx] <= rx.din;
                ch_strobe    <= 4'b0001 << ch_idx;
                // 2-bit counter wraps 3 -> 0 on the last channel.
                ch_idx       <= ch_idx + 2'd1;
                if (ch_idx == 2'd3 && frame_clean) begin
                  frame_valid <= 1'b1;
                end
              end
            end
          end

          default: begin
            state  <= HUNT;
            ch_idx <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule
